pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Hazard, flush and halt controller for the 5-stage CPU pipeline (IF, ID, EX, MEM, WB). It sits beside the decode stage. It keeps a register scoreboard and stalls PC and IF/ID on RAW/WAW hazards. It injects bubbles into ID/EX and sequences the multi-cycle wrong-path flush after a taken branch resolved in EX, whose redirect only reaches IF via MEM/WB. It also drains and parks the pipeline on a HALT opcode.

## Interface
Parameters:
- OP_W, 5, opcode width
- REG_AW, 4, register index width; NREG = 2**REG_AW
- PC_W, 7, branch target width
- FLUSH_CYCLES, 2, cycles of wrong-path suppression after a taken branch (≥1)
- HALT_OP, 5'h1F, opcode that halts the core

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_op  in  OP_W  ID opcode
- id_rs, id_rt, id_rd  in  REG_AW  ID register indices
- id_rs_use, id_rt_use  in  1  source is actually read
- id_rd_wr  in  1  instruction writes id_rd
- ex_branch_taken  in  1  branch in EX resolved taken
- ex_branch_target  in  PC_W  its target
- wb_wr_en  in  1  WB writes register file this cycle
- wb_rd  in  REG_AW  WB destination
- issue  out  1  ID instruction advances into ID/EX this cycle
- pc_stall  out  1  hold PC and IF/ID
- id_ex_bubble  out  1  load NOP into ID/EX
- if_id_flush  out  1  clear IF/ID
- pc_load  out  1  redirect PC this cycle
- pc_target  out  PC_W  redirect target
- halted  out  1  core parked
- pend_vec  out  NREG  scoreboard, debug
- stall_cnt, flush_cnt, issue_cnt  out  32 each  performance counters

## Operation
- Scoreboard: pend[NREG], one bit per register.
  - Set on issue & id_rd_wr & id_rd≠0.
  - Cleared on wb_wr_en at wb_rd.
  - Register 0 is never pending.
  - Same-register set and clear in the same cycle: set wins.
- hazard = id_valid & ((id_rs_use & pend[id_rs]) | (id_rt_use & pend[id_rt]) | (id_rd_wr & pend[id_rd])).
  - Uses registered pend, so a WB-cycle match still stalls and issue happens the next cycle.
  - WAW stall guarantees at most one in-flight writer per register.
- FSM states: RUN, FLUSH, DRAIN, HALTED.
  - RUN: issue = id_valid & ~hazard & ~ex_branch_taken.
    - On hazard: pc_stall=1, id_ex_bubble=1.
    - On ex_branch_taken: pc_load=1, pc_target=ex_branch_target, if_id_flush=1, id_ex_bubble=1, issue=0. Load flush counter with FLUSH_CYCLES-1; next state FLUSH, or RUN if FLUSH_CYCLES=1.
    - On issue of id_op==HALT_OP: next state DRAIN. The HALT itself does not set pend.
    - ex_branch_taken has priority over hazard and HALT.
  - FLUSH: if_id_flush=1, id_ex_bubble=1, issue=0. ex_branch_taken is ignored. Counter decrements each cycle; leave to RUN when it reaches 0.
  - DRAIN: pc_stall=1, id_ex_bubble=1, issue=0. When pend==0, go to HALTED.
  - HALTED: pc_stall=1, id_ex_bubble=1, halted=1. Exit only by reset.
- Idle: id_valid=0 in RUN gives no stall; id_ex_bubble=1 (nothing to issue), pc_stall=0.
- Arithmetic:
  - Counters wrap modulo 2^32.
  - Flush counter width is $clog2(FLUSH_CYCLES+1).

## Timing
- All control outputs are combinational from registered state plus current inputs, with zero-cycle latency. pend_vec, halted and the counters are registered.
- State, pend, flush counter and counters update on the rising clk edge.
- Taken-branch sequence: the cycle of ex_branch_taken plus FLUSH_CYCLES-1 following cycles have issue=0. The first new issue is possible FLUSH_CYCLES cycles after the branch cycle.
- Reset (rst_n=0 sampled at the edge, including mid-FLUSH or mid-DRAIN):
  - Registered state: state=RUN, pend=0, flush counter=0, counters=0, halted=0.
  - While rst_n=0, outputs are forced to: issue=0, pc_stall=1, id_ex_bubble=1, if_id_flush=1, pc_load=0, pc_target=0.

## Configuration
- PIPE_PERF_EN defined:
  - stall_cnt +1 per cycle with pc_stall & ~halted.
  - flush_cnt +1 per cycle with if_id_flush & rst_n.
  - issue_cnt +1 per issue.
- Undefined: counter registers are not built; all three ports are tied to 0. Port list is unchanged so the CPU top wiring is unchanged.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state enum (RUN, FLUSH, DRAIN, HALTED)
  - default widths OP_W/REG_AW/PC_W
  - HALT_OP default
  - counter width constant (32)
- Sub-module pipe_scoreboard holds pend storage, set/clear with set priority, three read ports and the empty flag. The FSM, flush counter and perf counters stay in pipe_hazard_ctrl.

## Test plan
- RAW:
  - Stimulus: issue op writing r3. Next ID reads r3 (rs_use=1). wb_wr_en with wb_rd=3 arrives 3 cycles later.
  - Required: pc_stall=1 / id_ex_bubble=1 through the WB cycle; issue=1 the cycle after; pend_vec[3] goes 1→0.
- Taken branch with FLUSH_CYCLES=2:
  - Stimulus: ex_branch_taken=1, target=7'h2A, id_valid=1.
  - Required: that cycle pc_load=1, pc_target=2A, if_id_flush=1, issue=0. Next cycle if_id_flush=1, issue=0. The third cycle issues.
- Simultaneous events:
  - Stimulus: issue writing r5 while wb_wr_en=1, wb_rd=5.
  - Required: pend_vec[5]=1 after the edge.
- HALT:
  - Stimulus: issue HALT_OP with r2 pending.
  - Required: DRAIN, pc_stall=1, halted=0 until WB r2 clears it; halted=1 the next cycle and stays high with id_valid toggling.
- Reset mid-FLUSH:
  - Stimulus: rst_n=0 one cycle after a taken branch.
  - Required: next cycle state RUN, pend_vec=0, and with no hazard id_valid=1 gives issue=1.
- PIPE_PERF_EN:
  - Stimulus: 4 issues, 3 stall cycles, one taken branch with FLUSH_CYCLES=2.
  - Required: issue_cnt=4, stall_cnt=3, flush_cnt=2. Without the macro all three read 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default widths for the pipeline hazard/flush/halt controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } ctrlState_e;

    localparam int DEF_OP_W   = 5;
    localparam int DEF_REG_AW = 4;
    localparam int DEF_PC_W   = 7;
    localparam logic [4:0] DEF_HALT_OP = 5'h1F;
    localparam int CNT_W      = 32;

endpackage

// File: rtl/pipe_scoreboard.sv
// Register pending-write scoreboard: one bit per register, set beats clear, r0 never pending.
module pipe_scoreboard
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   setEn,
    input  logic [REG_AW-1:0]      setIdx,
    input  logic                   clrEn,
    input  logic [REG_AW-1:0]      clrIdx,
    input  logic [REG_AW-1:0]      rdIdxA,
    input  logic [REG_AW-1:0]      rdIdxB,
    input  logic [REG_AW-1:0]      rdIdxC,
    output logic                   rdA,
    output logic                   rdB,
    output logic                   rdC,
    output logic [(2**REG_AW)-1:0] pendVec,
    output logic                   empty
);

    localparam int NREG = 2**REG_AW;
    localparam logic [NREG-1:0] NOT_R0 = {{(NREG-1){1'b1}}, 1'b0};

    logic [NREG-1:0] pend;
    logic [NREG-1:0] setMask;
    logic [NREG-1:0] clrMask;

    always_comb begin
        setMask = '0;
        clrMask = '0;
        if (setEn) setMask[setIdx] = 1'b1;
        if (clrEn) clrMask[clrIdx] = 1'b1;
    end

    // Clear first, then OR in the set so a same-cycle issue keeps the bit.
    always_ff @(posedge clk) begin
        if (!rst_n) pend <= '0;
        else        pend <= ((pend & ~clrMask) | setMask) & NOT_R0;
    end

    assign rdA     = pend[rdIdxA];
    assign rdB     = pend[rdIdxB];
    assign rdC     = pend[rdIdxC];
    assign pendVec = pend;
    assign empty   = (pend == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard stall, taken-branch flush and HALT drain controller for the 5-stage pipeline.
// Define PIPE_PERF_EN to build the stall/flush/issue performance counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int OP_W         = DEF_OP_W,
    parameter int REG_AW       = DEF_REG_AW,
    parameter int PC_W         = DEF_PC_W,
    parameter int FLUSH_CYCLES = 2,
    parameter logic [OP_W-1:0] HALT_OP = OP_W'(DEF_HALT_OP)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [OP_W-1:0]        id_op,
    input  logic [REG_AW-1:0]      id_rs,
    input  logic [REG_AW-1:0]      id_rt,
    input  logic [REG_AW-1:0]      id_rd,
    input  logic                   id_rs_use,
    input  logic                   id_rt_use,
    input  logic                   id_rd_wr,
    input  logic                   ex_branch_taken,
    input  logic [PC_W-1:0]        ex_branch_target,
    input  logic                   wb_wr_en,
    input  logic [REG_AW-1:0]      wb_rd,
    output logic                   issue,
    output logic                   pc_stall,
    output logic                   id_ex_bubble,
    output logic                   if_id_flush,
    output logic                   pc_load,
    output logic [PC_W-1:0]        pc_target,
    output logic                   halted,
    output logic [(2**REG_AW)-1:0] pend_vec,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [CNT_W-1:0]       flush_cnt,
    output logic [CNT_W-1:0]       issue_cnt
);

    localparam int FCW = $clog2(FLUSH_CYCLES + 1);

    ctrlState_e     state, stateNext;
    logic [FCW-1:0] flushCnt, flushNext;
    logic           rsPend, rtPend, rdPend, sbEmpty, hazard, sbSet;

    assign sbSet = issue & id_rd_wr & (id_rd != '0) & (id_op != HALT_OP);

    pipe_scoreboard #(.REG_AW(REG_AW)) u_scoreboard (
        .clk     (clk),
        .rst_n   (rst_n),
        .setEn   (sbSet),
        .setIdx  (id_rd),
        .clrEn   (wb_wr_en),
        .clrIdx  (wb_rd),
        .rdIdxA  (id_rs),
        .rdIdxB  (id_rt),
        .rdIdxC  (id_rd),
        .rdA     (rsPend),
        .rdB     (rtPend),
        .rdC     (rdPend),
        .pendVec (pend_vec),
        .empty   (sbEmpty)
    );

    // Registered pend: a WB in this cycle still stalls, issue follows next cycle.
    assign hazard = id_valid & ((id_rs_use & rsPend) | (id_rt_use & rtPend) | (id_rd_wr & rdPend));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            flushCnt <= '0;
        end else begin
            state    <= stateNext;
            flushCnt <= flushNext;
        end
    end

    always_comb begin
        issue        = 1'b0;
        pc_stall     = 1'b0;
        id_ex_bubble = 1'b1;
        if_id_flush  = 1'b0;
        pc_load      = 1'b0;
        pc_target    = '0;
        stateNext    = state;
        flushNext    = flushCnt;
        if (!rst_n) begin
            pc_stall    = 1'b1;
            if_id_flush = 1'b1;
        end else begin
            unique case (state)
                RUN: begin
                    if (ex_branch_taken) begin
                        pc_load     = 1'b1;
                        pc_target   = ex_branch_target;
                        if_id_flush = 1'b1;
                        flushNext   = FCW'(FLUSH_CYCLES - 1);
                        stateNext   = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                    end else if (hazard) begin
                        pc_stall = 1'b1;
                    end else if (id_valid) begin
                        issue        = 1'b1;
                        id_ex_bubble = 1'b0;
                        if (id_op == HALT_OP) stateNext = DRAIN;
                    end
                end
                FLUSH: begin
                    if_id_flush = 1'b1;
                    flushNext   = (flushCnt != '0) ? flushCnt - 1'b1 : '0;
                    if (flushCnt <= FCW'(1)) stateNext = RUN;
                end
                DRAIN: begin
                    pc_stall = 1'b1;
                    if (sbEmpty) stateNext = HALTED;
                end
                HALTED: begin
                    pc_stall = 1'b1;
                end
                default: stateNext = RUN;
            endcase
        end
    end

    assign halted = (state == HALTED);

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] stallCntQ, flushCntQ, issueCntQ;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stallCntQ <= '0;
            flushCntQ <= '0;
            issueCntQ <= '0;
        end else begin
            if (pc_stall & ~halted) stallCntQ <= stallCntQ + 1'b1;
            if (if_id_flush)        flushCntQ <= flushCntQ + 1'b1;
            if (issue)              issueCntQ <= issueCntQ + 1'b1;
        end
    end

    assign stall_cnt = stallCntQ;
    assign flush_cnt = flushCntQ;
    assign issue_cnt = issueCntQ;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
    assign issue_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: RAW/WAW stall, set-vs-clear, branch flush, HALT, reset mid-flush, counters.
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_op;
    logic [3:0]  id_rs, id_rt, id_rd;
    logic        id_rs_use, id_rt_use, id_rd_wr;
    logic        ex_branch_taken;
    logic [6:0]  ex_branch_target;
    logic        wb_wr_en;
    logic [3:0]  wb_rd;
    logic        issue, pc_stall, id_ex_bubble, if_id_flush, pc_load, halted;
    logic [6:0]  pc_target;
    logic [15:0] pend_vec;
    logic [31:0] stall_cnt, flush_cnt, issue_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_use(id_rs_use), .id_rt_use(id_rt_use), .id_rd_wr(id_rd_wr),
        .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .wb_wr_en(wb_wr_en), .wb_rd(wb_rd),
        .issue(issue), .pc_stall(pc_stall), .id_ex_bubble(id_ex_bubble),
        .if_id_flush(if_id_flush), .pc_load(pc_load), .pc_target(pc_target),
        .halted(halted), .pend_vec(pend_vec),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .issue_cnt(issue_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1-2ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] op, input logic [3:0] rs, input logic [3:0] rt,
                            input logic [3:0] rd, input logic rsu, input logic rtu, input logic rdw);
        id_valid = v; id_op = op; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_use = rsu; id_rt_use = rtu; id_rd_wr = rdw;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive_id(1'b0, 5'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        ex_branch_taken = 1'b0; ex_branch_target = 7'h00;
        wb_wr_en = 1'b0; wb_rd = 4'h0;
        #2;
        // Outputs forced while reset is asserted.
        chk("rst_issue",  {31'b0, issue}, 32'd0);
        chk("rst_stall",  {31'b0, pc_stall}, 32'd1);
        chk("rst_bubble", {31'b0, id_ex_bubble}, 32'd1);
        chk("rst_flush",  {31'b0, if_id_flush}, 32'd1);
        chk("rst_pcload", {31'b0, pc_load}, 32'd0);
        tick(); tick();
        chk("rst_pend",   {16'b0, pend_vec}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_icnt",   issue_cnt, 32'd0);
        rst_n = 1'b1;
        settle();
        chk("idle_stall",  {31'b0, pc_stall}, 32'd0);
        chk("idle_bubble", {31'b0, id_ex_bubble}, 32'd1);
        chk("idle_issue",  {31'b0, issue}, 32'd0);
        chk("idle_flush",  {31'b0, if_id_flush}, 32'd0);

        // RAW: writer of r3 issues, reader stalls through the WB cycle.
        drive_id(1'b1, 5'h01, 4'h1, 4'h2, 4'h3, 1'b0, 1'b0, 1'b1);
        settle();
        chk("raw_w_issue", {31'b0, issue}, 32'd1);
        tick();
        chk("raw_pend_set", {16'b0, pend_vec}, 32'h0008);
        drive_id(1'b1, 5'h02, 4'h3, 4'h0, 4'h4, 1'b1, 1'b0, 1'b0);
        settle();
        chk("raw_c1_stall", {31'b0, pc_stall}, 32'd1);
        chk("raw_c1_bub",   {31'b0, id_ex_bubble}, 32'd1);
        chk("raw_c1_issue", {31'b0, issue}, 32'd0);
        tick();
        chk("raw_c2_stall", {31'b0, pc_stall}, 32'd1);
        tick();
        wb_wr_en = 1'b1; wb_rd = 4'h3;
        settle();
        chk("raw_wb_stall", {31'b0, pc_stall}, 32'd1);
        chk("raw_wb_issue", {31'b0, issue}, 32'd0);
        tick();
        wb_wr_en = 1'b0;
        settle();
        chk("raw_pend_clr", {16'b0, pend_vec}, 32'h0000);
        chk("raw_go_issue", {31'b0, issue}, 32'd1);
        chk("raw_go_stall", {31'b0, pc_stall}, 32'd0);
        tick();

        // Set and clear of r5 in the same cycle: set wins.
        drive_id(1'b1, 5'h03, 4'h0, 4'h0, 4'h5, 1'b0, 1'b0, 1'b1);
        wb_wr_en = 1'b1; wb_rd = 4'h5;
        settle();
        chk("sim_issue", {31'b0, issue}, 32'd1);
        tick();
        chk("sim_pend", {16'b0, pend_vec}, 32'h0020);
        drive_id(1'b0, 5'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        tick();
        wb_wr_en = 1'b0;
        chk("sim_pend_clr", {16'b0, pend_vec}, 32'h0000);

        // Taken branch, FLUSH_CYCLES=2; a second branch during FLUSH is ignored.
        drive_id(1'b1, 5'h04, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        ex_branch_taken = 1'b1; ex_branch_target = 7'h2A;
        settle();
        chk("br0_pcload", {31'b0, pc_load}, 32'd1);
        chk("br0_target", {25'b0, pc_target}, 32'h2A);
        chk("br0_flush",  {31'b0, if_id_flush}, 32'd1);
        chk("br0_issue",  {31'b0, issue}, 32'd0);
        chk("br0_bubble", {31'b0, id_ex_bubble}, 32'd1);
        tick();
        ex_branch_target = 7'h11;
        settle();
        chk("br1_flush",  {31'b0, if_id_flush}, 32'd1);
        chk("br1_issue",  {31'b0, issue}, 32'd0);
        chk("br1_pcload", {31'b0, pc_load}, 32'd0);
        tick();
        ex_branch_taken = 1'b0;
        settle();
        chk("br2_issue", {31'b0, issue}, 32'd1);
        chk("br2_flush", {31'b0, if_id_flush}, 32'd0);
        tick();

        // So far: 4 issues, 3 stall cycles, 2 flush cycles.
`ifdef PIPE_PERF_EN
        chk("perf_issue", issue_cnt, 32'd4);
        chk("perf_stall", stall_cnt, 32'd3);
        chk("perf_flush", flush_cnt, 32'd2);
`else
        chk("perf_issue", issue_cnt, 32'd0);
        chk("perf_stall", stall_cnt, 32'd0);
        chk("perf_flush", flush_cnt, 32'd0);
`endif

        // HALT with r2 pending: drain, then park.
        drive_id(1'b1, 5'h05, 4'h0, 4'h0, 4'h2, 1'b0, 1'b0, 1'b1);
        tick();
        chk("halt_pend_r2", {16'b0, pend_vec}, 32'h0004);
        drive_id(1'b1, 5'h1F, 4'h0, 4'h0, 4'h7, 1'b0, 1'b0, 1'b1);
        settle();
        chk("halt_issue", {31'b0, issue}, 32'd1);
        tick();
        drive_id(1'b1, 5'h06, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("halt_nopend", {16'b0, pend_vec}, 32'h0004);
        chk("drain_stall", {31'b0, pc_stall}, 32'd1);
        chk("drain_issue", {31'b0, issue}, 32'd0);
        chk("drain_halted", {31'b0, halted}, 32'd0);
        tick();
        wb_wr_en = 1'b1; wb_rd = 4'h2;
        settle();
        chk("drain_wb_stall", {31'b0, pc_stall}, 32'd1);
        chk("drain_wb_halted", {31'b0, halted}, 32'd0);
        tick();
        wb_wr_en = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            id_valid = i[0];
            settle();
            chk("halted_hi", {31'b0, halted}, 32'd1);
            chk("halted_stall", {31'b0, pc_stall}, 32'd1);
            chk("halted_issue", {31'b0, issue}, 32'd0);
            tick();
        end

        // Reset mid-FLUSH with r6 pending.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive_id(1'b1, 5'h07, 4'h0, 4'h0, 4'h6, 1'b0, 1'b0, 1'b1);
        settle();
        chk("rf_w6_issue", {31'b0, issue}, 32'd1);
        tick();
        chk("rf_pend6", {16'b0, pend_vec}, 32'h0040);
        // WAW on r6 stalls.
        drive_id(1'b1, 5'h08, 4'h0, 4'h0, 4'h6, 1'b0, 1'b0, 1'b1);
        settle();
        chk("waw_stall", {31'b0, pc_stall}, 32'd1);
        chk("waw_issue", {31'b0, issue}, 32'd0);
        ex_branch_taken = 1'b1; ex_branch_target = 7'h33;
        tick();
        ex_branch_taken = 1'b0;
        rst_n = 1'b0;
        settle();
        chk("rf_rst_flush",  {31'b0, if_id_flush}, 32'd1);
        chk("rf_rst_pcload", {31'b0, pc_load}, 32'd0);
        chk("rf_rst_target", {25'b0, pc_target}, 32'h00);
        tick();
        rst_n = 1'b1;
        drive_id(1'b1, 5'h09, 4'h6, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1);
        settle();
        chk("rf_pend0",  {16'b0, pend_vec}, 32'h0000);
        chk("rf_issue",  {31'b0, issue}, 32'd1);
        chk("rf_flush",  {31'b0, if_id_flush}, 32'd0);
        chk("rf_halted", {31'b0, halted}, 32'd0);
        chk("rf_icnt",   issue_cnt, 32'd0);
        tick();
        chk("r0_never_pending", {16'b0, pend_vec}, 32'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety bound on total run time.
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
